// File: rtl/dma_sg_sequencer.sv
// dma_sg_sequencer: AXI-Lite master that builds a two-descriptor SG ring in
// BRAM, programs CURDESC/CR/TAILDESC and polls SR for the S2MM and MM2S
// channels of an AXI DMA. One outstanding transaction, S2MM has priority.
// Optional build macro DMA_SEQ_READBACK_EN: read back and compare every
// descriptor word right after it is written.
module dma_sg_sequencer #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] SG_BASE    = 32'h0000_0100,
    parameter logic [31:0] DMA_BASE   = 32'h0000_0000,
    parameter logic [31:0] BUF0_ADDR  = 32'hC000_0000,
    parameter logic [31:0] BUF1_ADDR  = 32'hC000_1000,
    parameter int unsigned LEN0       = 8,
    parameter int unsigned LEN1       = 56,
    parameter int unsigned POLL_GAP   = 16,
    parameter int unsigned POLL_MAX   = 1024
) (
    input  logic                    M_AXI_aclk,
    input  logic                    M_AXI_aresetn,
    input  logic                    start_s2mm,
    input  logic                    start_mm2s,
    output logic                    busy,
    output logic                    done_s2mm,
    output logic                    done_mm2s,
    output logic                    err,
    output logic [2:0]              err_code,
    output logic [ADDR_WIDTH-1:0]   M_AXI_awaddr,
    output logic [2:0]              M_AXI_awprot,
    output logic                    M_AXI_awvalid,
    input  logic                    M_AXI_awready,
    output logic [DATA_WIDTH-1:0]   M_AXI_wdata,
    output logic [DATA_WIDTH/8-1:0] M_AXI_wstrb,
    output logic                    M_AXI_wvalid,
    input  logic                    M_AXI_wready,
    input  logic [1:0]              M_AXI_bresp,
    input  logic                    M_AXI_bvalid,
    output logic                    M_AXI_bready,
    output logic [ADDR_WIDTH-1:0]   M_AXI_araddr,
    output logic [2:0]              M_AXI_arprot,
    output logic                    M_AXI_arvalid,
    input  logic                    M_AXI_arready,
    input  logic [DATA_WIDTH-1:0]   M_AXI_rdata,
    input  logic [1:0]              M_AXI_rresp,
    input  logic                    M_AXI_rvalid,
    output logic                    M_AXI_rready
);

    localparam int unsigned PCW = $clog2(POLL_MAX + 1);
    localparam int unsigned GCW = $clog2(POLL_GAP + 1);

    typedef enum logic [3:0] {
        IDLE, GRANT, WR_REQ, WR_RESP, POLL_WAIT,
        RD_REQ, RD_DATA, CLEAR_REQ, CLEAR_RESP, FIN
    } state_t;

    state_t          state;
    logic            pending_s2mm, pending_mm2s;
    logic            chan;          // 0 = S2MM, 1 = MM2S
    logic [3:0]      step;
    logic            issued;        // request already presented for this state
    logic            rb;            // current read is a descriptor readback
    logic [PCW-1:0]  poll_cnt;
    logic [GCW-1:0]  gap_cnt;
    logic [31:0]     clear_val;
    logic [31:0]     d0_c, d1_c, sr_addr_c, wr_addr_c, wr_data_c;
    logic            aw_ok_c, w_ok_c;
    logic            unused_rdata_c;

    assign M_AXI_awprot   = 3'b000;
    assign M_AXI_arprot   = 3'b000;
    assign M_AXI_wstrb    = '1;
    assign unused_rdata_c = &{1'b0, M_AXI_rdata};
    assign aw_ok_c        = !M_AXI_awvalid || M_AXI_awready;
    assign w_ok_c         = !M_AXI_wvalid || M_AXI_wready;

    // Write list: address and data of the current step for the active channel
    always_comb begin
        d0_c      = SG_BASE + (chan ? 32'h80 : 32'h00);
        d1_c      = d0_c + 32'h40;
        sr_addr_c = DMA_BASE + (chan ? 32'h04 : 32'h34);
        wr_addr_c = '0;
        wr_data_c = '0;
        case (step)
            4'd0: begin wr_addr_c = d0_c;          wr_data_c = d1_c; end
            4'd1: begin wr_addr_c = d0_c + 32'h08; wr_data_c = BUF0_ADDR; end
            4'd2: begin wr_addr_c = d0_c + 32'h18; wr_data_c = {4'h0, 1'b1, 1'b0, 26'(LEN0)}; end
            4'd3: begin wr_addr_c = d1_c;          wr_data_c = d0_c; end
            4'd4: begin wr_addr_c = d1_c + 32'h08; wr_data_c = BUF1_ADDR; end
            4'd5: begin wr_addr_c = d1_c + 32'h18; wr_data_c = {4'h0, 1'b0, 1'b1, 26'(LEN1)}; end
            4'd6: begin wr_addr_c = DMA_BASE + (chan ? 32'h08 : 32'h38); wr_data_c = d0_c; end
            4'd7: begin wr_addr_c = DMA_BASE + (chan ? 32'h00 : 32'h30); wr_data_c = 32'h0000_1001; end
            default: begin wr_addr_c = DMA_BASE + (chan ? 32'h10 : 32'h40); wr_data_c = d1_c; end
        endcase
    end

    // Sequencer FSM with registered AXI-Lite master and status outputs
    always_ff @(posedge M_AXI_aclk or negedge M_AXI_aresetn) begin
        if (!M_AXI_aresetn) begin
            state         <= IDLE;
            pending_s2mm  <= 1'b0;
            pending_mm2s  <= 1'b0;
            chan          <= 1'b0;
            step          <= 4'd0;
            issued        <= 1'b0;
            rb            <= 1'b0;
            poll_cnt      <= '0;
            gap_cnt       <= '0;
            clear_val     <= 32'h0;
            busy          <= 1'b0;
            done_s2mm     <= 1'b0;
            done_mm2s     <= 1'b0;
            err           <= 1'b0;
            err_code      <= 3'b000;
            M_AXI_awaddr  <= '0;
            M_AXI_awvalid <= 1'b0;
            M_AXI_wdata   <= '0;
            M_AXI_wvalid  <= 1'b0;
            M_AXI_bready  <= 1'b0;
            M_AXI_araddr  <= '0;
            M_AXI_arvalid <= 1'b0;
            M_AXI_rready  <= 1'b0;
        end else begin
            done_s2mm <= 1'b0;
            done_mm2s <= 1'b0;
            if (start_s2mm) pending_s2mm <= 1'b1;
            if (start_mm2s) pending_mm2s <= 1'b1;
            case (state)
                IDLE: begin
                    if (pending_s2mm) begin
                        chan         <= 1'b0;
                        pending_s2mm <= start_s2mm;
                        busy         <= 1'b1;
                        err          <= 1'b0;
                        err_code     <= 3'b000;
                        state        <= GRANT;
                    end else if (pending_mm2s) begin
                        chan         <= 1'b1;
                        pending_mm2s <= start_mm2s;
                        busy         <= 1'b1;
                        err          <= 1'b0;
                        err_code     <= 3'b000;
                        state        <= GRANT;
                    end
                end
                GRANT: begin
                    step   <= 4'd0;
                    issued <= 1'b0;
                    state  <= WR_REQ;
                end
                WR_REQ, CLEAR_REQ: begin
                    if (!issued) begin
                        issued        <= 1'b1;
                        M_AXI_awvalid <= 1'b1;
                        M_AXI_wvalid  <= 1'b1;
                        M_AXI_awaddr  <= ADDR_WIDTH'((state == CLEAR_REQ) ? sr_addr_c : wr_addr_c);
                        M_AXI_wdata   <= DATA_WIDTH'((state == CLEAR_REQ) ? clear_val : wr_data_c);
                    end else begin
                        if (M_AXI_awready) M_AXI_awvalid <= 1'b0;
                        if (M_AXI_wready)  M_AXI_wvalid  <= 1'b0;
                        if (aw_ok_c && w_ok_c) begin
                            M_AXI_bready <= 1'b1;
                            issued       <= 1'b0;
                            state        <= (state == CLEAR_REQ) ? CLEAR_RESP : WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (M_AXI_bvalid) begin
                        M_AXI_bready <= 1'b0;
                        if (M_AXI_bresp != 2'b00) begin
                            err_code[0] <= 1'b1;
                            state       <= FIN;
                        end
`ifdef DMA_SEQ_READBACK_EN
                        else if (step < 4'd6) begin
                            rb    <= 1'b1;
                            state <= RD_REQ;
                        end
`endif
                        else if (step == 4'd8) begin
                            poll_cnt <= '0;
                            gap_cnt  <= '0;
                            state    <= POLL_WAIT;
                        end else begin
                            step  <= step + 4'd1;
                            state <= WR_REQ;
                        end
                    end
                end
                POLL_WAIT: begin
                    if (gap_cnt == GCW'(POLL_GAP - 1)) begin
                        gap_cnt <= '0;
                        state   <= RD_REQ;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                RD_REQ: begin
                    if (!issued) begin
                        issued        <= 1'b1;
                        M_AXI_arvalid <= 1'b1;
                        M_AXI_rready  <= 1'b1;
                        M_AXI_araddr  <= ADDR_WIDTH'(rb ? wr_addr_c : sr_addr_c);
                    end else if (M_AXI_arready) begin
                        M_AXI_arvalid <= 1'b0;
                        issued        <= 1'b0;
                        state         <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (M_AXI_rvalid) begin
                        M_AXI_rready <= 1'b0;
                        if (M_AXI_rresp != 2'b00) begin
                            err_code[0] <= 1'b1;
                            state       <= FIN;
                        end
`ifdef DMA_SEQ_READBACK_EN
                        else if (rb) begin
                            rb <= 1'b0;
                            if (M_AXI_rdata != M_AXI_wdata) begin
                                err_code[0] <= 1'b1;
                                state       <= FIN;
                            end else begin
                                step  <= step + 4'd1;
                                state <= WR_REQ;
                            end
                        end
`endif
                        // an SR error wins over IOC so a fault is never masked
                        else if (M_AXI_rdata[6:4] != 3'd0) begin
                            err_code[1] <= 1'b1;
                            clear_val   <= 32'h0000_7000;
                            state       <= CLEAR_REQ;
                        end else if (M_AXI_rdata[12]) begin
                            clear_val <= 32'h0000_1000;
                            state     <= CLEAR_REQ;
                        end else if (poll_cnt == PCW'(POLL_MAX - 1)) begin
                            err_code[2] <= 1'b1;
                            state       <= FIN;
                        end else begin
                            poll_cnt <= poll_cnt + 1'b1;
                            state    <= POLL_WAIT;
                        end
                    end
                end
                CLEAR_RESP: begin
                    if (M_AXI_bvalid) begin
                        M_AXI_bready <= 1'b0;
                        if (M_AXI_bresp != 2'b00) err_code[0] <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    if (chan) done_mm2s <= 1'b1;
                    else      done_s2mm <= 1'b1;
                    err   <= |err_code;
                    busy  <= pending_s2mm | pending_mm2s | start_s2mm | start_mm2s;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
